// File: rtl/uart_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module     : uart_tx_scheduler_pkg
// Description: Shared types and constants for the UART transmit scheduler.
//              Holds the transmit FSM encoding, the frame format and the
//              round-robin index helper used by the arbiter.
// Revision   : 1.0 - initial release
// ============================================================================
package uart_tx_scheduler_pkg;

   // Transmit FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   // 8N1 frame format
   localparam int c_UART_DATA_BITS = 8;
   localparam int c_BIT_CNT_W      = $clog2(c_UART_DATA_BITS);

   // Index reached by stepping 'offset' places past 'base' on an n-entry ring.
   function automatic int rr_index(input int base, input int offset, input int n);
      return (base + offset) % n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : uart_tx_scheduler_rr_arbiter
// Description: Combinational round-robin arbiter with burst lock.
//              The last granted requester keeps the grant while it holds
//              lock and req and its burst has not reached MAX_BURST bytes;
//              otherwise the first active request after last_grant wins.
// Ports      : req_i        - request vector
//              lock_i       - burst lock vector
//              last_grant_i - previously granted index
//              burst_cnt_i  - bytes already granted in the current burst - 1
//              grant_o      - selected requester
//              valid_o      - at least one request present
//              hold_o       - grant is a burst continuation (count up)
// Revision   : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler_rr_arbiter
   import uart_tx_scheduler_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 8,
   parameter int GW        = $clog2(N_REQ),
   parameter int BW        = $clog2(MAX_BURST) + 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [N_REQ-1:0] lock_i,
   input  logic [GW-1:0]    last_grant_i,
   input  logic [BW-1:0]    burst_cnt_i,
   output logic [GW-1:0]    grant_o,
   output logic             valid_o,
   output logic             hold_o
);

   logic [GW-1:0] w_idx;

   always_comb begin
      hold_o  = lock_i[last_grant_i] && req_i[last_grant_i] &&
                (burst_cnt_i < BW'(MAX_BURST - 1));
      valid_o = |req_i;
      grant_o = last_grant_i;
      w_idx   = last_grant_i;
      if (!hold_o) begin
         // Scan from the farthest ring position towards the nearest so the
         // nearest active requester after last_grant is written last and wins.
         // Offset N_REQ is last_grant itself, which therefore ranks lowest.
         for (int i = N_REQ; i >= 1; i--) begin
            w_idx = GW'(rr_index(int'(last_grant_i), i, N_REQ));
            if (req_i[w_idx]) begin
               grant_o = w_idx;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module     : uart_tx_scheduler
// Description: Shares one 8N1 UART transmit line among N_REQ requesters.
//              Arbitration happens on a bit tick in IDLE or at the end of a
//              stop bit, so frames run back-to-back while requests remain.
//              All line changes happen on the cycle after a txclk_en tick.
// Ports      : clk_50m  - system clock
//              rst      - synchronous active-high reset
//              txclk_en - one-cycle bit-period strobe
//              req      - per-requester byte ready
//              lock     - per-requester burst lock
//              data     - packed bytes, data[8i+7:8i] belongs to requester i
//              ack      - one-cycle pulse, byte of requester i latched
//              tx       - serial line, idle high
//              busy     - high from grant until the stop bit ends
//              grant_id - index of current / last granted requester
// Revision   : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
   import uart_tx_scheduler_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 8,
   parameter int GW        = $clog2(N_REQ)
) (
   input  logic                 clk_50m,
   input  logic                 rst,
   input  logic                 txclk_en,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     lock,
   input  logic [8*N_REQ-1:0]   data,
   output logic [N_REQ-1:0]     ack,
   output logic                 tx,
   output logic                 busy,
   output logic [GW-1:0]        grant_id
);

   localparam int BW = $clog2(MAX_BURST) + 1;

   tx_state_t                    state_q;
   logic [c_UART_DATA_BITS-1:0]  shift_q;
   logic [c_BIT_CNT_W-1:0]       bit_cnt_q;
   logic                         tx_q;
   logic                         busy_q;
   logic [N_REQ-1:0]             ack_q;
   logic [GW-1:0]                grant_q;
   logic [GW-1:0]                last_q;
   logic [BW-1:0]                burst_q;

   logic [GW-1:0]                w_grant;
   logic                         w_valid;
   logic                         w_hold;
   logic [N_REQ-1:0]             w_onehot;

   uart_tx_scheduler_rr_arbiter #(
      .N_REQ     (N_REQ),
      .MAX_BURST (MAX_BURST),
      .GW        (GW),
      .BW        (BW)
   ) u_arb (
      .req_i        (req),
      .lock_i       (lock),
      .last_grant_i (last_q),
      .burst_cnt_i  (burst_q),
      .grant_o      (w_grant),
      .valid_o      (w_valid),
      .hold_o       (w_hold)
   );

   assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_grant;

   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         ack_q     <= '0;
         grant_q   <= '0;
         last_q    <= GW'(N_REQ - 1);
         burst_q   <= '0;
      end else begin
         ack_q <= '0;
         if (txclk_en) begin
            case (state_q)
               // End of stop bit behaves like IDLE so frames chain without a gap
               ST_IDLE, ST_STOP: begin
                  if (w_valid) begin
                     shift_q <= data[{w_grant, 3'b000} +: c_UART_DATA_BITS];
                     ack_q   <= w_onehot;
                     grant_q <= w_grant;
                     last_q  <= w_grant;
                     burst_q <= w_hold ? burst_q + 1'b1 : '0;
                     busy_q  <= 1'b1;
                     tx_q    <= 1'b0;
                     state_q <= ST_START;
                  end else begin
                     busy_q  <= 1'b0;
                     tx_q    <= 1'b1;
                     state_q <= ST_IDLE;
                  end
               end
               ST_START: begin
                  tx_q      <= shift_q[0];
                  shift_q   <= shift_q >> 1;
                  bit_cnt_q <= '0;
                  state_q   <= ST_DATA;
               end
               ST_DATA: begin
                  if (bit_cnt_q == c_BIT_CNT_W'(c_UART_DATA_BITS - 1)) begin
                     tx_q    <= 1'b1;
                     state_q <= ST_STOP;
                  end else begin
                     tx_q      <= shift_q[0];
                     shift_q   <= shift_q >> 1;
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign ack      = ack_q;
   assign tx       = tx_q;
   assign busy     = busy_q;
   assign grant_id = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module     : tb_uart_tx_scheduler
// Description: Self-checking bench for uart_tx_scheduler. A frame-level
//              reference model tracks the line every cycle; directed vectors
//              and sequences cover arbitration, bursts and reset corners.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

   localparam int N_REQ     = 4;
   localparam int MAX_BURST = 8;

   logic        clk_50m  = 1'b0;
   logic        rst      = 1'b1;
   logic        txclk_en = 1'b0;
   logic [3:0]  req      = '0;
   logic [3:0]  lock     = '0;
   logic [31:0] data     = '0;
   logic [3:0]  ack;
   logic        tx;
   logic        busy;
   logic [1:0]  grant_id;

   int checks   = 0;
   int failures = 0;

   always #10 clk_50m = ~clk_50m;

   uart_tx_scheduler #(
      .N_REQ     (N_REQ),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk_50m  (clk_50m),
      .rst      (rst),
      .txclk_en (txclk_en),
      .req      (req),
      .lock     (lock),
      .data     (data),
      .ack      (ack),
      .tx       (tx),
      .busy     (busy),
      .grant_id (grant_id)
   );

   // Tick generator: updates 1 ns after the rising edge
   int   tick_per  = 8;
   bit   tick_auto = 1'b1;
   logic tick_man  = 1'b0;
   int   tick_cnt  = 0;

   always @(posedge clk_50m) begin
      #1;
      if (tick_auto) begin
         tick_cnt = (tick_cnt + 1 >= tick_per) ? 0 : tick_cnt + 1;
         txclk_en = (tick_cnt == 0);
      end else begin
         txclk_en = tick_man;
      end
   end

   // Reference model: a frame is a 10-entry line vector walked one entry per tick
   int         m_pos   = 0;
   logic [9:0] m_frame = '1;
   logic       m_line  = 1'b1;
   logic       m_busy  = 1'b0;
   logic [3:0] m_ack   = '0;
   int         m_grant = 0;
   int         m_last  = N_REQ - 1;
   int         m_burst = 0;
   int         m_g;

   always @(posedge clk_50m) begin
      if (rst) begin
         m_pos = 0; m_line = 1'b1; m_busy = 1'b0; m_ack = '0;
         m_grant = 0; m_last = N_REQ - 1; m_burst = 0;
      end else begin
         m_ack = '0;
         if (txclk_en) begin
            if (m_pos == 0 || m_pos == 10) begin
               if (req != 0) begin
                  if (lock[m_last] && req[m_last] && m_burst < MAX_BURST - 1) begin
                     m_g = m_last;
                     m_burst++;
                  end else begin
                     m_g = -1;
                     for (int k = 1; k <= N_REQ; k++)
                        if (m_g < 0 && req[(m_last + k) % N_REQ]) m_g = (m_last + k) % N_REQ;
                     m_burst = 0;
                  end
                  m_frame = {1'b1, data[m_g*8 +: 8], 1'b0};
                  m_line  = m_frame[0];
                  m_pos   = 1;
                  m_busy  = 1'b1;
                  m_ack   = 4'b0001 << m_g;
                  m_grant = m_g;
                  m_last  = m_g;
               end else begin
                  m_pos = 0; m_line = 1'b1; m_busy = 1'b0;
               end
            end else begin
               m_line = m_frame[m_pos];
               m_pos++;
            end
         end
      end
   end

   bit chk_en = 1'b0;
   int model_prints = 0;

   always @(negedge clk_50m) begin
      if (chk_en) begin
         checks++;
         if (tx !== m_line || busy !== m_busy || ack !== m_ack || grant_id !== m_grant[1:0]) begin
            failures++;
            if (model_prints < 10) begin
               model_prints++;
               $display("FAIL model @%0t: tx=%b busy=%b ack=%b grant=%0d, required tx=%b busy=%b ack=%b grant=%0d",
                        $time, tx, busy, ack, grant_id, m_line, m_busy, m_ack, m_grant);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_50m);
      rst = 1'b1;
      repeat (2) @(negedge clk_50m);
      rst = 1'b0;
   endtask

   // Waits for a non-zero ack; counts ticks seen and any busy-low cycle on the way
   task automatic wait_ack(input int budget, output int idx, output int nticks, output bit busy_drop);
      idx = -1; nticks = 0; busy_drop = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk_50m);
         if (txclk_en) nticks++;
         if (!busy) busy_drop = 1'b1;
         if (ack != 0) begin
            for (int k = 0; k < N_REQ; k++) if (ack[k]) idx = k;
            return;
         end
      end
   endtask

   // Samples the line on each tick cycle starting at the current falling edge
   task automatic recv_frame(input int budget, output logic [9:0] f);
      int k;
      k = 0;
      f = '0;
      for (int c = 0; c < budget && k < 10; c++) begin
         if (c > 0) @(negedge clk_50m);
         if (txclk_en) begin
            f[k] = tx;
            k++;
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      for (int c = 0; c < budget && busy; c++) @(negedge clk_50m);
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [3:0]  lock;
      logic [31:0] data;
      int          per;
      int          exp_g;
   } vec_t;

   vec_t        vt [8];
   int          idx, nt, viol;
   bit          bd, any_drop;
   logic [9:0]  f;
   logic [31:0] dtmp;
   logic [7:0]  exp_b;
   int          exp_burst [12];

   initial begin
      vt[0] = '{4'b0100, 4'b0000, 32'h00A5_0000, 434, 2};
      vt[1] = '{4'b1111, 4'b0000, 32'h1122_3344,  16, 3};
      vt[2] = '{4'b0011, 4'b0000, 32'hDEAD_BEEF,  16, 0};
      vt[3] = '{4'b0011, 4'b0000, 32'h0F0F_3C5A,   8, 1};
      vt[4] = '{4'b0010, 4'b0010, 32'h0000_8100,   8, 1};
      vt[5] = '{4'b1010, 4'b0000, 32'h7E00_FF00,   8, 3};
      vt[6] = '{4'b0001, 4'b0000, 32'h0000_00FF,   4, 0};
      vt[7] = '{4'b0001, 4'b0000, 32'h0000_0001,   4, 0};
      exp_burst = '{1, 1, 1, 1, 1, 1, 1, 1, 3, 1, 1, 1};

      repeat (3) @(negedge clk_50m);
      rst = 1'b0;
      chk_en = 1'b1;
      check("reset_tx", 32'(tx), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_ack", 32'(ack), 32'd0);
      check("reset_grant", 32'(grant_id), 32'd0);

      // Table of single frames; data is scrambled right after ack
      for (int v = 0; v < 8; v++) begin
         tick_per = vt[v].per;
         @(negedge clk_50m);
         req = vt[v].req; lock = vt[v].lock; data = vt[v].data;
         wait_ack(20 * vt[v].per + 50, idx, nt, bd);
         check($sformatf("vec%0d_ack", v), 32'(idx), 32'(vt[v].exp_g));
         check($sformatf("vec%0d_grant", v), 32'(grant_id), 32'(vt[v].exp_g));
         req = '0; lock = '0; data = ~data;
         dtmp  = vt[v].data;
         exp_b = dtmp[vt[v].exp_g*8 +: 8];
         recv_frame(12 * vt[v].per + 50, f);
         check($sformatf("vec%0d_frame", v), 32'(f), 32'({1'b1, exp_b, 1'b0}));
         if (v == 0) check("a5_line_seq", 32'(f), 32'b11_0100_1010);
         wait_idle(vt[v].per + 5);
         check($sformatf("vec%0d_busy_end", v), 32'(busy), 32'd0);
      end

      // Back-to-back round robin
      do_reset();
      tick_per = 6;
      @(negedge clk_50m);
      req = 4'b1111; data = 32'h8844_2211;
      any_drop = 1'b0;
      for (int n = 0; n < 8; n++) begin
         wait_ack(15 * 6 + 20, idx, nt, bd);
         check($sformatf("rr%0d_grant", n), 32'(idx), 32'(n % 4));
         if (n > 0) begin
            check($sformatf("rr%0d_ticks", n), 32'(nt), 32'd10);
            any_drop = any_drop | bd;
         end
      end
      check("rr_no_idle_gap", 32'(any_drop), 32'd0);
      req = '0;
      wait_idle(12 * 6 + 10);

      // Burst lock: requester 1 locked, requester 3 waiting
      do_reset();
      tick_per = 4;
      @(negedge clk_50m);
      lock = 4'b0010; req = 4'b1010; data = 32'hC300_1C00;
      for (int n = 0; n < 12; n++) begin
         wait_ack(15 * 4 + 20, idx, nt, bd);
         check($sformatf("burst%0d_grant", n), 32'(idx), 32'(exp_burst[n]));
      end
      req = '0; lock = '0;
      wait_idle(12 * 4 + 10);

      // Request withdrawn before any tick
      do_reset();
      tick_auto = 1'b0; tick_man = 1'b0;
      @(negedge clk_50m);
      req = 4'b0001;
      repeat (3) @(negedge clk_50m);
      req = '0;
      tick_per = 4; tick_auto = 1'b1;
      viol = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk_50m);
         if (ack != 0 || tx !== 1'b1 || busy !== 1'b0) viol++;
      end
      check("withdraw_quiet", 32'(viol), 32'd0);

      // Reset during data bit 4, then a fresh full frame
      do_reset();
      tick_per = 8;
      @(negedge clk_50m);
      req = 4'b0100; data = 32'h00A5_0000;
      wait_ack(20 * 8, idx, nt, bd);
      check("midrst_first_ack", 32'(idx), 32'd2);
      req = '0;
      nt = 0;
      for (int c = 0; c < 200 && nt < 5; c++) begin
         if (c > 0) @(negedge clk_50m);
         if (txclk_en) nt++;
      end
      @(negedge clk_50m);
      check("midrst_busy_before", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk_50m);
      rst = 1'b0;
      check("midrst_tx", 32'(tx), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ack", 32'(ack), 32'd0);
      check("midrst_grant", 32'(grant_id), 32'd0);
      req = 4'b0010; data = 32'h0000_3C00;
      wait_ack(20 * 8, idx, nt, bd);
      check("midrst_restart_ack", 32'(idx), 32'd1);
      req = '0;
      recv_frame(12 * 8 + 20, f);
      check("midrst_restart_frame", 32'(f), 32'({1'b1, 8'h3C, 1'b0}));
      wait_idle(20);

      // txclk_en held high: every cycle is a bit period
      tick_per = 1;
      @(negedge clk_50m);
      req = 4'b1000; data = 32'h5A00_0000;
      wait_ack(20, idx, nt, bd);
      check("cont_tick_ack", 32'(idx), 32'd3);
      req = '0;
      recv_frame(20, f);
      check("cont_tick_frame", 32'(f), 32'({1'b1, 8'h5A, 1'b0}));
      wait_idle(10);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk_50m);
         if (c % 500 == 0) tick_per = $urandom_range(1, 5);
         rst = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 3) == 0) req  = 4'($urandom);
         if ($urandom_range(0, 3) == 0) lock = 4'($urandom);
         if ($urandom_range(0, 7) == 0) data = $urandom;
      end
      @(negedge clk_50m);
      rst = 1'b0; req = '0; lock = '0;
      repeat (100) @(negedge clk_50m);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
